// File: rtl/vid_frame_sequencer_if.sv
// Link between the frame sequencer and the BMP-driven stream source it controls.
// src_begin is a one-cycle launch pulse, src_done a one-cycle end-of-frame strobe,
// src_valid qualifies each pixel; there is no back-pressure, so no ready signal exists.
interface vid_frame_sequencer_if;
   logic src_begin;
   logic src_done;
   logic src_valid;

   modport master (output src_begin, input src_done, input src_valid);
   modport slave  (input src_begin, output src_done, output src_valid);
endinterface

// File: rtl/vid_frame_sequencer.sv
// Multi-frame sequencer for a stream source: launches frames, waits for done, inserts gaps,
// and checks line length, line count and done timeout of each frame.
module vid_frame_sequencer #(
   parameter int NUM_FRAMES  = 4,
   parameter int GAP_CYCLES  = 16,
   parameter int H_DISP      = 1280,
   parameter int V_DISP      = 720,
   parameter int TIMEOUT_CYC = 1500000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   vid_frame_sequencer_if.master src,
   output logic                  busy,
   output logic [15:0]           frame_idx,
   output logic                  seq_done,
   output logic                  err_hlen,
   output logic                  err_vcnt,
   output logic                  err_tmo,
   output logic [15:0]           last_line_len,
   output logic [2:0]            o_dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_GAP       = 3'd3,
      S_FINISH    = 3'd4
   } state_t;

   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [15:0]   LAST_FRAME = 16'(NUM_FRAMES - 1);
   localparam logic [15:0]   H_LEN      = 16'(H_DISP);
   localparam logic [16:0]   V_LEN      = 17'(V_DISP);

   state_t          r_state;
   state_t          w_next;
   logic [TW-1:0]   r_tmo_cnt;
   logic [GW-1:0]   r_gap_cnt;
   logic            r_src_begin;
   logic            r_busy;
   logic            r_seq_done;
   logic [15:0]     r_frame_idx;
   logic            r_err_hlen;
   logic            r_err_vcnt;
   logic            r_err_tmo;
   logic [15:0]     r_last_len;
   logic [15:0]     r_run;
   logic [15:0]     r_line_cnt;
   logic            r_prev_valid;

   logic            w_in_wait;
   logic            w_line_end;
   logic            w_done_ok;
   logic            w_tmo;
   logic            w_last;
   logic            w_accept;
   logic [16:0]     w_lines;

   assign w_in_wait  = (r_state == S_WAIT_DONE);
   assign w_line_end = r_prev_valid & ~src.src_valid;
   // abort outranks src_done and the timeout, so neither may act in an abort cycle
   assign w_done_ok  = w_in_wait & src.src_done & ~abort;
   assign w_tmo      = w_in_wait & ~src.src_done & ~abort & (r_tmo_cnt == TMO_LAST);
   assign w_last     = (r_frame_idx == LAST_FRAME);
   assign w_accept   = (r_state == S_IDLE) & start;
   assign w_lines    = {1'b0, r_line_cnt} + {16'd0, w_line_end};

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (start) w_next = S_LAUNCH;
         S_LAUNCH:    w_next = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (src.src_done) begin
               if (w_last)               w_next = S_FINISH;
               else if (GAP_CYCLES == 0) w_next = S_LAUNCH;
               else                      w_next = S_GAP;
            end else if (r_tmo_cnt == TMO_LAST) begin
               w_next = S_FINISH;
            end
         end
         S_GAP:       if (r_gap_cnt == GAP_LAST) w_next = S_LAUNCH;
         S_FINISH:    w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
      if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
   end

   // Control outputs are registered from the next state so they line up with the state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_src_begin <= 1'b0;
         r_busy      <= 1'b0;
         r_seq_done  <= 1'b0;
         r_tmo_cnt   <= '0;
         r_gap_cnt   <= '0;
      end else begin
         r_src_begin <= (w_next == S_LAUNCH);
         r_busy      <= (w_next == S_LAUNCH) || (w_next == S_WAIT_DONE) || (w_next == S_GAP);
         r_seq_done  <= (w_next == S_FINISH);
         r_tmo_cnt   <= (w_in_wait && (w_next == S_WAIT_DONE)) ? r_tmo_cnt + TW'(1) : '0;
         r_gap_cnt   <= ((r_state == S_GAP) && (w_next == S_GAP)) ? r_gap_cnt + GW'(1) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_frame_idx <= '0;
         r_err_tmo   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_frame_idx <= '0;
            r_err_tmo   <= 1'b0;
         end
         if (w_done_ok && !w_last) r_frame_idx <= r_frame_idx + 16'd1;
         if (w_tmo)                r_err_tmo   <= 1'b1;
      end
   end

   // Line/frame checker; only meaningful while a frame is outstanding
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_run        <= '0;
         r_line_cnt   <= '0;
         r_prev_valid <= 1'b0;
         r_last_len   <= '0;
         r_err_hlen   <= 1'b0;
         r_err_vcnt   <= 1'b0;
      end else if (w_in_wait) begin
         r_prev_valid <= src.src_valid;
         if (src.src_valid) begin
            if (r_run != 16'hFFFF) r_run <= r_run + 16'd1;
         end else if (r_prev_valid) begin
            r_last_len <= r_run;
            if (r_run != H_LEN) r_err_hlen <= 1'b1;
            r_line_cnt <= r_line_cnt + 16'd1;
            r_run      <= '0;
         end
         if (w_done_ok) begin
            if (w_lines != V_LEN) r_err_vcnt <= 1'b1;
            r_line_cnt   <= '0;
            r_run        <= '0;
            r_prev_valid <= 1'b0;
         end
      end else begin
         r_run        <= '0;
         r_line_cnt   <= '0;
         r_prev_valid <= 1'b0;
         if (w_accept) begin
            r_err_hlen <= 1'b0;
            r_err_vcnt <= 1'b0;
         end
      end
   end

   assign src.src_begin = r_src_begin;
   assign busy          = r_busy;
   assign frame_idx     = r_frame_idx;
   assign seq_done      = r_seq_done;
   assign err_hlen      = r_err_hlen;
   assign err_vcnt      = r_err_vcnt;
   assign err_tmo       = r_err_tmo;
   assign last_line_len = r_last_len;
   assign o_dbg_state   = r_state;

endmodule
